// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_e   : controller FSM states (RUN, MEM_WAIT)
//   REG_AW_DEF: default register-file address width
//   ctrl_t    : bundle of the seven pipeline-register control outputs
//   CTRL_*    : the fixed control patterns the controller can emit
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_flush;
  } ctrl_t;

  // Normal flow: everything advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                    idex_en: 1'b1, idex_flush: 1'b0,
                                    exmem_en: 1'b1, memwb_flush: 1'b0};
  // Reset: all registers load, all flushable registers load NOPs.
  localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                    idex_en: 1'b1, idex_flush: 1'b1,
                                    exmem_en: 1'b1, memwb_flush: 1'b1};
  // Memory wait: freeze the front of the pipe, bubble into MEM/WB so the
  // stalled instruction is not written back twice.
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                    idex_en: 1'b0, idex_flush: 1'b0,
                                    exmem_en: 1'b0, memwb_flush: 1'b1};
  // Taken branch: squash the two wrong-path instructions behind EX.
  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                    idex_en: 1'b1, idex_flush: 1'b1,
                                    exmem_en: 1'b1, memwb_flush: 1'b0};
  // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
  localparam ctrl_t CTRL_LOADUSE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                     idex_en: 1'b1, idex_flush: 1'b1,
                                     exmem_en: 1'b1, memwb_flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for performance debug.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for a 5-stage pipeline. Resolves load-use hazards
// (detected at ID), taken branches (resolved at EX) and multi-cycle data
// memory accesses (in MEM). Control outputs are combinational from state and
// inputs; state and counters are registered.
//   clk, rst                      : clock, synchronous active-high reset
//   idex_mem_read, idex_rd        : load in ID/EX and its destination
//   ifid_rs1/rs2, ifid_uses_rs2   : sources of the instruction in IF/ID
//   ex_branch_taken               : taken branch/jump resolved in EX
//   mem_req, mem_ready            : data-memory handshake for EX/MEM
//   pc_en .. memwb_flush          : pipeline register enables / flushes
//   stall_cnt, flush_cnt          : saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_uses_rs2,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              memwb_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   load_use;
  logic   freeze;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) ||
                     (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Freeze while waiting, and also in the cycle that starts the wait. In the
  // release cycle (mem_ready=1) this drops and the RUN priorities apply to
  // whatever inputs are present then; branches/lu seen during the wait are
  // simply never acted upon.
  assign freeze = ((state_q == MEM_WAIT) || mem_req) && !mem_ready;

  always_comb begin
    ctrl = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_branch_taken) begin
      // The dependent instruction is on the wrong path, so flush beats lu.
      ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = CTRL_LOADUSE;
    end
  end

  // RUN->MEM_WAIT on an unfinished request, MEM_WAIT->RUN on mem_ready;
  // both collapse to "next state is MEM_WAIT exactly when frozen".
  always_comb begin
    state_d = freeze ? MEM_WAIT : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_flush = ctrl.memwb_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.ifid_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  // Expected output patterns {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  localparam logic [6:0] E_RST = 7'b1111111;
  localparam logic [6:0] E_RUN = 7'b1101010;
  localparam logic [6:0] E_FRZ = 7'b0000001;
  localparam logic [6:0] E_BR  = 7'b1111110;
  localparam logic [6:0] E_LU  = 7'b0001110;

  typedef struct packed {
    logic              rst;
    logic              mem_read;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              uses_rs2;
    logic              br;
    logic              mreq;
    logic              mrdy;
    logic [6:0]        exp_ctrl;
    logic [CNT_W-1:0]  exp_stall;
    logic [CNT_W-1:0]  exp_flush;
  } vec_t;

  typedef struct packed {
    logic [6:0]       ctrl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              idex_mem_read;
  logic [REG_AW-1:0] idex_rd;
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              ifid_uses_rs2;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [6:0]        act_ctrl;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  localparam int NV = 26;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  assign act_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .idex_mem_read   (idex_mem_read),
    .idex_rd         (idex_rd),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_uses_rs2   (ifid_uses_rs2),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .memwb_flush     (memwb_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  function automatic vec_t mk(input int r, input int mr, input int rd, input int rs1,
                              input int rs2, input int u, input int br, input int mq,
                              input int my, input logic [6:0] e, input int s, input int f);
    vec_t v;
    v.rst       = 1'(r);
    v.mem_read  = 1'(mr);
    v.rd        = REG_AW'(rd);
    v.rs1       = REG_AW'(rs1);
    v.rs2       = REG_AW'(rs2);
    v.uses_rs2  = 1'(u);
    v.br        = 1'(br);
    v.mreq      = 1'(mq);
    v.mrdy      = 1'(my);
    v.exp_ctrl  = e;
    v.exp_stall = CNT_W'(s);
    v.exp_flush = CNT_W'(f);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
  endtask

  // Drive one cycle: push expectation, compare outputs mid-cycle, counters after the edge.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    rst             = v.rst;
    idex_mem_read   = v.mem_read;
    idex_rd         = v.rd;
    ifid_rs1        = v.rs1;
    ifid_rs2        = v.rs2;
    ifid_uses_rs2   = v.uses_rs2;
    ex_branch_taken = v.br;
    mem_req         = v.mreq;
    mem_ready       = v.mrdy;
    sb_q.push_back('{ctrl: v.exp_ctrl, stall: v.exp_stall, flush: v.exp_flush});
    @(negedge clk);
    e = sb_q.pop_front();
    check("ctrl", idx, act_ctrl, e.ctrl);
    @(posedge clk);
    #1;
    check("cnts", idx, {stall_cnt, flush_cnt}, {e.stall, e.flush});
    $display("step %0d rst=%0b lu_in=%0b/%0d/%0d/%0d br=%0b req=%0b rdy=%0b ctrl=%b stall=%0d flush=%0d",
             idx, v.rst, v.mem_read, v.rd, v.rs1, v.rs2, v.br, v.mreq, v.mrdy,
             act_ctrl, stall_cnt, flush_cnt);
  endtask

  initial begin
    //              rst mr rd rs1 rs2 u br mq my  ctrl   stall flush
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);
    vecs[3]  = mk(0, 1, 5, 5, 0, 0, 0, 0, 0, E_LU,  1, 0);  // lu on rs1
    vecs[4]  = mk(0, 0, 5, 5, 0, 0, 0, 0, 0, E_RUN, 1, 0);  // single bubble only
    vecs[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN, 1, 0);  // rd=0 never hazards
    vecs[6]  = mk(0, 1, 7, 3, 7, 1, 0, 0, 0, E_LU,  2, 0);  // lu on rs2
    vecs[7]  = mk(0, 1, 7, 3, 7, 0, 0, 0, 0, E_RUN, 2, 0);  // rs2 not used
    vecs[8]  = mk(0, 0, 5, 5, 0, 0, 0, 0, 0, E_RUN, 2, 0);  // not a load
    vecs[9]  = mk(0, 1, 5, 5, 0, 0, 1, 0, 0, E_BR,  2, 1);  // branch beats lu
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR,  2, 2);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, 2, 2);  // single-cycle access
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 3, 2);  // enter wait
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, 4, 2);  // branch ignored
    vecs[14] = mk(0, 1, 5, 5, 0, 0, 0, 1, 0, E_FRZ, 5, 2);  // lu ignored
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, 5, 2);  // release
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 5, 2);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 5, 2);  // no req, no wait
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 6, 2);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ, 7, 2);  // wait holds until ready
    vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_RST, 0, 0);  // reset mid-wait
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);  // back in RUN
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR,  0, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 1, 1);
    vecs[24] = mk(0, 1, 9, 0, 9, 1, 0, 0, 1, E_LU,  2, 1);  // release cycle re-evaluates lu
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 2, 1);

    rst = 1'b1; idex_mem_read = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    ifid_uses_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Saturation: reset, then hold lu for 20 cycles; stall_cnt must stick at 15.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; idex_mem_read = 1'b1; idex_rd = 5'd4; ifid_rs1 = 5'd4;
    ifid_uses_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      sb_q.push_back('{ctrl: E_LU, stall: CNT_W'((i + 1 > 15) ? 15 : i + 1), flush: '0});
      @(negedge clk);
      e = sb_q.pop_front();
      check("sat_ctrl", i, act_ctrl, e.ctrl);
      @(posedge clk);
      #1;
      check("sat_cnt", i, {3'b000, stall_cnt}, {3'b000, e.stall});
      $display("sat cycle %0d ctrl=%b stall=%0d", i, act_ctrl, stall_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. Resolves three hazard sources:
- load-use data hazards detected at ID;
- taken branches/jumps resolved at EX;
- multi-cycle data-memory accesses in MEM.

Keeps saturating stall and flush event counters for performance debug.

## Interface
- REG_AW, 5, register-file address width
- CNT_W, 16, width of each performance counter
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- idex_mem_read  in  1  instruction in ID/EX is a load
- idex_rd  in  REG_AW  destination register of instruction in ID/EX
- ifid_rs1  in  REG_AW  source register 1 of instruction in IF/ID
- ifid_rs2  in  REG_AW  source register 2 of instruction in IF/ID
- ifid_uses_rs2  in  1  instruction in IF/ID reads rs2
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_req  in  1  instruction in EX/MEM needs a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads zero (NOP)
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX loads zero (bubble)
- exmem_en  out  1  EX/MEM load enable
- memwb_flush  out  1  MEM/WB loads zero
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  branch flush events

## Operation
- Load-use hazard (lu) is asserted when all of the following hold:
  - idex_mem_read=1;
  - idex_rd≠0;
  - idex_rd==ifid_rs1, or (ifid_uses_rs2 and idex_rd==ifid_rs2).
- FSM states and transitions:
  - RUN:
    - mem_req=1 and mem_ready=0 → MEM_WAIT.
    - Otherwise stay in RUN.
  - MEM_WAIT:
    - Freeze the whole pipeline: pc_en=ifid_en=idex_en=exmem_en=0.
    - memwb_flush=1, so no duplicate writeback occurs.
    - On mem_ready=1 → RUN. That cycle releases the freeze (outputs as in RUN).
- RUN output priority, highest first:
  1. Entering-wait condition (mem_req and !mem_ready): same freeze outputs as MEM_WAIT.
  2. ex_branch_taken:
     - ifid_flush=1, idex_flush=1;
     - pc_en=ifid_en=idex_en=exmem_en=1;
     - flush overrides lu, because the dependent instruction is on the wrong path.
  3. lu:
     - pc_en=0, ifid_en=0;
     - idex_flush=1, idex_en=1;
     - exmem_en=1.
  4. Otherwise: all enables 1, all flushes 0.
- Flush and enable are independent: a flushed register loads zero only when its enable is 1.
- Counters:
  - stall_cnt increments on every cycle with pc_en=0.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones; no wrap.
- A branch or lu arriving during MEM_WAIT is ignored. The inputs are re-evaluated in the release cycle.

## Timing
- All outputs are combinational from the current state and inputs; they are consumed at the next rising edge by the pipeline registers.
- State and counters are registered.
- Reset:
  - state=RUN, stall_cnt=0, flush_cnt=0.
  - While rst=1, outputs force pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=idex_flush=memwb_flush=1, so the pipeline fills with NOPs.
- Reset asserted in MEM_WAIT returns to RUN on the next edge. The pending access is abandoned.
- Load-use costs exactly 1 bubble cycle; branch costs 2 flushed slots; a memory wait costs N freeze cycles for N cycles of mem_ready=0.
- mem_req=1 with mem_ready=1 in the same cycle means a single-cycle access: no stall, and the FSM stays in RUN.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT};
  - REG_AW default;
  - a struct bundling the seven control outputs (reused by the top-level wiring).
- One sub-module: sat_counter (parameter CNT_W, inputs clk/rst/inc, output count), instantiated twice.
- Hazard compare logic stays inline.

## Test plan
- Reset: rst=1 for 2 cycles → all enables 1, all flushes 1, counters 0. Release → RUN, flushes 0.
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs1=5 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1. Same stimulus with idex_rd=0 → no stall.
- Branch + lu together: ex_branch_taken=1 with lu true → ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → 3 cycles with all enables 0 and memwb_flush=1, then release; stall_cnt=3. Branch asserted mid-wait has no effect.
- Reset mid-wait: enter MEM_WAIT, assert rst → next cycle state=RUN, counters 0.
- Saturation: CNT_W=4, hold lu true for 20 cycles → stall_cnt stops at 15.
